// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states and widths for the UART transmit arbiter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, SEND, SETTLE, DRAIN} state_t;
    localparam int CNT_W = 16;
    localparam int ID_W = 3;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus transmitter handshake of the arbiter
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
    import uart_pkg::*;
    logic [NREQ-1:0] req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] gnt;
    logic [7:0] uart_data;
    logic uart_load;
    logic uart_empty;
    logic busy;
    logic abort;
    logic [ID_W-1:0] abort_id;
    modport master (
        output req_valid, req_data, req_last, uart_empty,
        input req_ready, gnt, uart_data, uart_load, busy, abort, abort_id
    );
    modport slave (
        input req_valid, req_data, req_last, uart_empty,
        output req_ready, gnt, uart_data, uart_load, busy, abort, abort_id
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first valid requester searching upward from the one after ptr
module rr_pick import uart_pkg::*; #(
    parameter int NREQ = 4
) (
    input logic [NREQ-1:0] valid,
    input logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] onehot,
    output logic [ID_W-1:0] idx,
    output logic any
);
    int j;
    logic [NREQ-1:0] sh;
    always_comb begin
        onehot = '0;
        idx = '0;
        any = 1'b0;
        j = 0;
        sh = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            sh = valid >> j;
            if (!any && sh[0]) begin
                any = 1'b1;
                idx = ID_W'(j);
                onehot = {{(NREQ-1){1'b0}}, 1'b1} << j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding one UART transmitter
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int NREQ = 4,
    parameter int TIMEOUT = 1023
) (
    input logic clk12,
    input logic rst_n,
    uart_tx_arbiter_if.slave bus
);
    state_t state;
    logic [ID_W-1:0] ptr, g, pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic pick_any, last_f, valid_g;
    logic [CNT_W-1:0] cnt;
    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid(bus.req_valid),
        .ptr(ptr),
        .onehot(pick_oh),
        .idx(pick_idx),
        .any(pick_any)
    );
    // gnt is one-hot of g, so masking avoids a variable-width index
    assign valid_g = |(bus.req_valid & bus.gnt);
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= ID_W'(NREQ - 1);
            g <= '0;
            last_f <= 1'b0;
            cnt <= '0;
            bus.gnt <= '0;
            bus.req_ready <= '0;
            bus.uart_load <= 1'b0;
            bus.uart_data <= '0;
            bus.abort <= 1'b0;
            bus.abort_id <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.uart_load <= 1'b0;
            bus.abort <= 1'b0;
            case (state)
                IDLE:
                    if (pick_any) begin
                        bus.gnt <= pick_oh;
                        g <= pick_idx;
                        cnt <= '0;
                        state <= SEND;
                    end
                SEND:
                    if (valid_g && bus.uart_empty) begin
                        bus.uart_data <= 8'(bus.req_data >> {g, 3'b000});
                        bus.uart_load <= 1'b1;
                        bus.req_ready <= bus.gnt;
                        last_f <= |(bus.req_last & bus.gnt);
                        cnt <= '0;
                        state <= SETTLE;
                    end else if (!valid_g && cnt == CNT_W'(TIMEOUT)) begin
                        bus.abort <= 1'b1;
                        bus.abort_id <= g;
                        bus.gnt <= '0;
                        ptr <= g;
                        cnt <= '0;
                        state <= IDLE;
                    end else if (!valid_g) begin
                        cnt <= cnt + 1'b1;
                    end
                SETTLE: state <= DRAIN;
                DRAIN:
                    if (bus.uart_empty) begin
                        if (last_f) begin
                            bus.gnt <= '0;
                            ptr <= g;
                            state <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
